// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the fetch stage and its IF/ID register.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HELD  = 2'd2
  } fetch_state_t;

  // addi x0,x0,0 -- what decode sees while IF/ID holds a bubble
  localparam word_t FETCH_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_ifid_latch.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
// pc4 is computed here so it always tracks the stored pc.
module ifid_latch
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  load,
  input  logic  bubble,
  input  word_t instr_in,
  input  word_t pc_in,
  output logic  valid,
  output word_t instr,
  output word_t pc,
  output word_t pc4
);

  logic  valid_q, valid_d;
  word_t instr_q, instr_d;
  word_t pc_q, pc_d;
  word_t pc4_q, pc4_d;

  // Next-value select: bubble wins over load, otherwise hold
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (bubble) begin
      valid_d = 1'b0;
      instr_d = FETCH_NOP;
      pc_d    = '0;
      pc4_d   = '0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
      pc4_d   = pc_in + 32'd4;
    end
  end

  // IF/ID flops; reset leaves a bubble
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= 1'b0;
      instr_q <= FETCH_NOP;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem request handshake, stall/flush FSM.
// Optional build macro FETCH_PERF_EN adds fetch and stall-cycle counters.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_load,
  input  logic        ihit,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles,
`endif
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pending_q, pending_d;
  word_t        held_q, held_d;

  logic  fire;
  logic  ifid_load;
  logic  ifid_bubble;
  word_t ifid_src;

  assign fire = pc_write & ifid_write;

  // Request outputs depend only on state and PC; reset forces the request low
  assign imem_ren  = (state_q != HELD) & ~RST;
  assign imem_addr = pc_q;

  // Next-state, PC and IF/ID control
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = pending_q;
    held_d      = held_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_src    = imem_load;
    unique case (state_q)
      FETCH: begin
        if (ihit) begin
          if (flush) begin
            pc_d        = redirect_pc;
            ifid_bubble = 1'b1;
          end else if (fire) begin
            ifid_load = 1'b1;
            pc_d      = pc_q + 32'd4;
          end else begin
            held_d  = imem_load;
            state_d = HELD;
          end
        end else if (flush) begin
          // request is still outstanding, so park the target until it completes
          pending_d   = redirect_pc;
          ifid_bubble = 1'b1;
          state_d     = DRAIN;
        end else if (ifid_write) begin
          ifid_bubble = 1'b1;
        end
      end
      DRAIN: begin
        ifid_bubble = 1'b1;
        if (flush) pending_d = redirect_pc;
        if (ihit) begin
          // a flush arriving on the completing cycle is the newest target
          pc_d    = flush ? redirect_pc : pending_q;
          state_d = FETCH;
        end
      end
      HELD: begin
        ifid_src = held_q;
        if (flush) begin
          pc_d        = redirect_pc;
          ifid_bubble = 1'b1;
          state_d     = FETCH;
        end else if (fire) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + 32'd4;
          state_d   = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // FSM and fetch-side registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FETCH;
      pc_q      <= PC_INIT;
      pending_q <= '0;
      held_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      held_q    <= held_d;
    end
  end

  ifid_latch u_ifid (
    .CLK      (CLK),
    .RST      (RST),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (ifid_src),
    .pc_in    (pc_q),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .pc       (ifid_pc),
    .pc4      (ifid_pc4)
  );

`ifdef FETCH_PERF_EN
  word_t fetched_q, fetched_d;
  word_t stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q + {31'd0, ifid_load};
    stall_d   = stall_q + {31'd0, (imem_ren & ~ihit) | (state_q == HELD)};
  end

  // Wrapping performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched      = fetched_q;
  assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage (PC_INIT = 32'h200).
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        pc_write, ifid_write, flush, ihit;
  logic [31:0] redirect_pc;
  logic        imem_ren;
  logic [31:0] imem_addr, imem_load;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cycles;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  // memory word content is a fixed function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_load = mem_word(imem_addr);

  fetch_stage #(.PC_INIT(32'h200)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_ren    (imem_ren),
    .imem_addr   (imem_addr),
    .imem_load   (imem_load),
    .ihit        (ihit),
`ifdef FETCH_PERF_EN
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; pc_write = 1'b1; ifid_write = 1'b1;
    flush = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_ren",   {31'd0, imem_ren}, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'h13);
    chk("rst_addr",  imem_addr, 32'h200);

    @(posedge CLK); #1;
    RST = 1'b0; #1;
    chk("rel_ren",  {31'd0, imem_ren}, 32'd1);
    chk("rel_addr", imem_addr, 32'h200);

    // zero-wait streaming
    ihit = 1'b1;
    tick();
    chk("s0_addr",  imem_addr, 32'h204);
    chk("s0_valid", {31'd0, ifid_valid}, 32'd1);
    chk("s0_pc",    ifid_pc, 32'h200);
    chk("s0_pc4",   ifid_pc4, 32'h204);
    chk("s0_instr", ifid_instr, mem_word(32'h200));
    tick();
    chk("s1_addr",  imem_addr, 32'h208);
    chk("s1_pc",    ifid_pc, 32'h204);
    chk("s1_pc4",   ifid_pc4, 32'h208);
    tick();
    chk("s2_pc",    ifid_pc, 32'h208);
    chk("s2_addr",  imem_addr, 32'h20C);

    // redirect to 3C with ihit: data discarded, bubble
    flush = 1'b1; redirect_pc = 32'h3C;
    tick();
    flush = 1'b0;
    chk("rd_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rd_addr",  imem_addr, 32'h3C);
    tick();
    chk("f3c_pc",   ifid_pc, 32'h3C);
    chk("f3c_addr", imem_addr, 32'h40);

    // stall with ihit at 40 -> HELD
    pc_write = 1'b0; ifid_write = 1'b0;
    tick();
    ihit = 1'b0;
    chk("h0_ren",   {31'd0, imem_ren}, 32'd0);
    chk("h0_pc",    ifid_pc, 32'h3C);
    chk("h0_valid", {31'd0, ifid_valid}, 32'd1);
    for (int i = 1; i < 3; i++) begin
      tick();
      chk($sformatf("h%0d_ren", i), {31'd0, imem_ren}, 32'd0);
      chk($sformatf("h%0d_pc", i),  ifid_pc, 32'h3C);
    end
    pc_write = 1'b1; ifid_write = 1'b1;
    tick();
    chk("hr_pc",    ifid_pc, 32'h40);
    chk("hr_instr", ifid_instr, mem_word(32'h40));
    chk("hr_addr",  imem_addr, 32'h44);
    chk("hr_ren",   {31'd0, imem_ren}, 32'd1);

    // 3-cycle latency, flush in wait cycle 1
    flush = 1'b1; redirect_pc = 32'h100;
    tick();
    flush = 1'b0;
    chk("d1_addr",  imem_addr, 32'h44);
    chk("d1_ren",   {31'd0, imem_ren}, 32'd1);
    chk("d1_valid", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("d2_addr",  imem_addr, 32'h44);
    chk("d2_valid", {31'd0, ifid_valid}, 32'd0);
    ihit = 1'b1;
    tick();
    ihit = 1'b0;
    chk("d3_addr",  imem_addr, 32'h100);
    chk("d3_valid", {31'd0, ifid_valid}, 32'd0);

    // two flushes while draining: newest target wins
    flush = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("dd1_addr", imem_addr, 32'h100);
    redirect_pc = 32'h180;
    tick();
    flush = 1'b0; ihit = 1'b1;
    tick();
    chk("dd_addr",  imem_addr, 32'h180);
    chk("dd_valid", {31'd0, ifid_valid}, 32'd0);
    tick();
    chk("f180_pc",   ifid_pc, 32'h180);
    chk("f180_addr", imem_addr, 32'h184);

    // flush beats stall
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC; pc_write = 1'b0; ifid_write = 1'b0;
    tick();
    flush = 1'b0; pc_write = 1'b1; ifid_write = 1'b1;
    chk("fs_valid", {31'd0, ifid_valid}, 32'd0);
    chk("fs_instr", ifid_instr, 32'h13);
    chk("fs_pc",    ifid_pc, 32'h0);
    chk("fs_pc4",   ifid_pc4, 32'h0);
    chk("fs_addr",  imem_addr, 32'hFFFF_FFFC);

    // PC wrap
    tick();
    chk("w_pc",   ifid_pc, 32'hFFFF_FFFC);
    chk("w_pc4",  ifid_pc4, 32'h0);
    chk("w_addr", imem_addr, 32'h0);

    // enter HELD then reset asynchronously
    pc_write = 1'b0; ifid_write = 1'b0;
    tick();
    ihit = 1'b0;
    chk("mh_ren", {31'd0, imem_ren}, 32'd0);
    #2;
    RST = 1'b1;
    #1;
    chk("ar_valid", {31'd0, ifid_valid}, 32'd0);
    chk("ar_instr", ifid_instr, 32'h13);
    chk("ar_addr",  imem_addr, 32'h200);
    chk("ar_ren",   {31'd0, imem_ren}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; pc_write = 1'b1; ifid_write = 1'b1;
    #1;
    chk("ar2_ren",  {31'd0, imem_ren}, 32'd1);
    chk("ar2_addr", imem_addr, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline. It owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register. It consumes the hazard unit's `pc_write`, `ifid_write` and `flush` outputs and the MEM-stage redirect target. It feeds the decode stage, which drives the hazard unit's ID-stage instruction field.

## Interface
Parameters:
- `PC_INIT`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `CLK`  in  1: single clock; all state updates on the rising edge.
- `RST`  in  1: asynchronous reset, active-high.
- `pc_write`  in  1: 0 means stall; PC must not advance.
- `ifid_write`  in  1: 0 means hold the IF/ID register.
- `flush`  in  1: taken branch/jal/jalr in MEM; redirect and squash.
- `redirect_pc`  in  32: target PC, valid when `flush`=1.
- `imem_ren`  out  1: instruction read request.
- `imem_addr`  out  32: request address; stable while `imem_ren`=1 until `ihit`.
- `imem_load`  in  32: instruction data, valid when `ihit`=1.
- `ihit`  in  1: request completes this cycle.
- `ifid_valid`  out  1: IF/ID holds a real instruction.
- `ifid_instr`  out  32: IF/ID instruction.
- `ifid_pc`  out  32: PC of `ifid_instr`.
- `ifid_pc4`  out  32: `ifid_pc` + 4, modulo 2^32.

## Operation
FSM states: FETCH, DRAIN, HELD. `fire` = `pc_write` & `ifid_write`.

**FETCH**
- Drives `imem_ren`=1 and `imem_addr`=PC.
- `ihit`&`flush`: discard the data; PC <= `redirect_pc`; IF/ID <= bubble; stay in FETCH.
- `ihit`&`fire`: IF/ID <= {1, `imem_load`, PC, PC+4}; PC <= PC+4.
- `ihit` with stall: hold register <= `imem_load`; go to HELD; IF/ID unchanged.
- No `ihit` with `flush`: pending <= `redirect_pc`; IF/ID <= bubble; go to DRAIN. The address must stay stable.
- No `ihit` with `ifid_write`=1: IF/ID <= bubble.
- No `ihit` with `ifid_write`=0: IF/ID held.

**DRAIN**
- Drives `imem_ren`=1 at the old address.
- A repeated `flush` overwrites pending; the newest target wins.
- `ihit`: discard the data; PC <= pending; go to FETCH.
- IF/ID stays bubble.

**HELD**
- Drives `imem_ren`=0.
- `flush`: drop the held word; PC <= `redirect_pc`; IF/ID <= bubble; go to FETCH.
- `fire`: IF/ID <= {1, held, PC, PC+4}; PC <= PC+4; go to FETCH.

**General rules**
- Bubble = {`ifid_valid`=0, `ifid_instr`=FETCH_NOP, pc=0, pc4=0}.
- `flush` beats stall: a flush bubbles IF/ID even when `ifid_write`=0.
- PC arithmetic is 32-bit wrap: 32'hFFFF_FFFC + 4 = 0. No alignment checks.

## Timing
- Reset (async, immediate):
  - PC = `PC_INIT`, state = FETCH.
  - IF/ID = bubble, `imem_ren`=0 while `RST`=1.
  - After `RST` falls, `imem_ren`=1 combinationally in the same cycle.
- `imem_ren` and `imem_addr` are combinational from state and PC only. They must not depend on `ihit`, `flush` or the stall inputs.
- Latency: `ihit` in cycle N with `fire` puts IF/ID valid at the edge ending N. The next request address is presented in N+1.
- A zero-wait memory (`ihit` every cycle) sustains one instruction per cycle.
- HELD adds no cycle: release in cycle M presents the held word at the edge ending M and refetches in M+1.
- `RST` asserted mid-DRAIN or mid-HELD abandons pending and held state. Memory must tolerate the dropped request.

## Configuration
`FETCH_PERF_EN`:
- When defined, adds outputs `perf_fetched` (out, 32) and `perf_stall_cycles` (out, 32).
  - `perf_fetched` counts IF/ID loads with `ifid_valid`=1.
  - `perf_stall_cycles` counts cycles with `imem_ren`=1 & !`ihit`, plus cycles in HELD.
  - Both counters wrap, and `RST` clears them to 0.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- In `cpu_types_pkg`:
  - `word_t` (32-bit).
  - `fetch_state_t` enum {FETCH, DRAIN, HELD}.
  - constant `FETCH_NOP` = 32'h0000_0013 (addi x0,x0,0).
- Sub-module `ifid_latch`: the IF/ID register with load, bubble and hold controls. It is the only place IF/ID flops live. The FSM, PC, pending and hold registers stay in `fetch_stage`.

## Test plan
- Reset with `PC_INIT`=32'h200, zero-wait memory, no stalls: `imem_addr` = 200, 204, 208 on consecutive cycles. `ifid_pc` lags by one cycle and `ifid_pc4` = `ifid_pc`+4.
- `ihit` while `pc_write`=`ifid_write`=0 for 3 cycles at PC 32'h40:
  - state is HELD and `imem_ren`=0.
  - IF/ID is unchanged during the stall.
  - On release, IF/ID = held word with pc 40, and the next address is 44.
- 3-cycle memory latency with `flush` (`redirect_pc`=32'h100) in wait cycle 1:
  - `imem_addr` holds the old PC until `ihit`, and that data is discarded.
  - The next request is at 100.
  - IF/ID stays invalid throughout.
- Two flushes in DRAIN (targets 32'h100, then 32'h180): the refetch goes to 180.
- `flush` and `ifid_write`=0 in the same cycle: IF/ID becomes the bubble (`ifid_valid`=0, `ifid_instr`=32'h13).
- PC at 32'hFFFF_FFFC with `ihit`: `ifid_pc4`=0 and the next `imem_addr`=0. Assert `RST` mid-HELD: PC=`PC_INIT` and IF/ID is the bubble immediately.
